// File: rtl/adder_accum_seq_pkg.sv
// Shared definitions for the sequential accumulator.
// FSM state encoding and default widths.
package adder_accum_seq_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned E_DEF = 4;
  localparam int unsigned L_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/adder_accum_seq_add_cout_n.sv
// Parameterized W-bit adder with carry-out.
// Used as the accumulator datapath adder.
module add_cout_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/adder_accum_seq.sv
// Sequential accumulator: sums a framed job of N-bit operands.
// Optional saturation on overflow: ADDER_ACCUM_SATURATE_EN.
module adder_accum_seq
  import adder_accum_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int E = E_DEF,
  parameter int L = L_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [L-1:0]   len,
  input  logic           din_valid,
  input  logic [N-1:0]   din,
  output logic           din_ready,
  output logic           busy,
  output logic           done_tick,
  output logic [N+E-1:0] acc,
  output logic           ovf
);

  localparam int W = N + E;
  localparam logic [L-1:0] CNT_ONE = L'(1);

  state_e         state_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic           ovf_q;
  logic [L-1:0]   cnt_q;
  logic           done_q;
  logic           busy_q;
  logic           rdy_q;
  logic [W-1:0]   sum;
  logic           cout;

  add_cout_n #(.W(W)) u_add (
    .a_i   (acc_q),
    .b_i   ({{E{1'b0}}, din}),
    .sum_o (sum),
    .cout_o(cout)
  );

  // Value the accumulator takes when an operand is accepted.
  always_comb begin
    acc_d = sum;
`ifdef ADDER_ACCUM_SATURATE_EN
    if (cout) acc_d = '1;
`endif
  end

  // Job-framing FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              cnt_q   <= len;
              rdy_q   <= 1'b1;
              state_q <= ST_ACC;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ACC: begin
          if (din_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | cout;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              rdy_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign din_ready = rdy_q;
  assign busy      = busy_q;
  assign done_tick = done_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule
